// File: rtl/branch_issue_fsm_if.sv
// rtl/branch_issue_fsm_if.sv - instruction-issue / condition-FSM signal bundle
// Purpose: groups the instruction handshake, ALU/branch controls, PC load and
//          counters of branch_issue_fsm.
// Ports (signals):
//   instr_in/instr_valid_in/instr_ready_out   instruction handshake
//   we_reg_out, alu_op_out, dr/sr1/sr2_out, imm_en_out, imm_out   ALU controls
//   br_out, n/z/p_dec_out, pc_ctl_0_in         branch request and decision
//   pc_load_out, pc_offset_out                 PC update
//   illegal_out, retired_cnt_out, taken_cnt_out   status
// Modports: slave = issue FSM, master = instruction source / condition FSM.
interface branch_issue_fsm_if #(
    parameter int CNT_W = 16
);
    logic [15:0]      instr_in;
    logic             instr_valid_in;
    logic             instr_ready_out;
    logic             we_reg_out;
    logic [1:0]       alu_op_out;
    logic [2:0]       dr_out;
    logic [2:0]       sr1_out;
    logic [2:0]       sr2_out;
    logic             imm_en_out;
    logic [15:0]      imm_out;
    logic             br_out;
    logic             n_dec_out;
    logic             z_dec_out;
    logic             p_dec_out;
    logic             pc_ctl_0_in;
    logic             pc_load_out;
    logic [15:0]      pc_offset_out;
    logic             illegal_out;
    logic [CNT_W-1:0] retired_cnt_out;
    logic [CNT_W-1:0] taken_cnt_out;

    modport slave (
        input  instr_in, instr_valid_in, pc_ctl_0_in,
        output instr_ready_out, we_reg_out, alu_op_out, dr_out, sr1_out, sr2_out,
               imm_en_out, imm_out, br_out, n_dec_out, z_dec_out, p_dec_out,
               pc_load_out, pc_offset_out, illegal_out, retired_cnt_out, taken_cnt_out
    );

    modport master (
        output instr_in, instr_valid_in, pc_ctl_0_in,
        input  instr_ready_out, we_reg_out, alu_op_out, dr_out, sr1_out, sr2_out,
               imm_en_out, imm_out, br_out, n_dec_out, z_dec_out, p_dec_out,
               pc_load_out, pc_offset_out, illegal_out, retired_cnt_out, taken_cnt_out
    );
endinterface

// File: rtl/branch_issue_fsm.sv
// rtl/branch_issue_fsm.sv - ADD/AND/NOT/BR issue FSM driving ALU and branch controls
// Purpose: accepts one instruction at a time, decodes it, issues ALU controls or a
//          branch request, then turns the returned decision into a PC-load pulse.
// Ports:
//   clka      system clock, rising edge
//   reset_in  synchronous active-high reset
//   bus       branch_issue_fsm_if.slave (handshake, controls, counters)
module branch_issue_fsm #(
    parameter int CNT_W = 16
) (
    input  logic              clka,
    input  logic              reset_in,
    branch_issue_fsm_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DECODE  = 2'd1,
        S_EXEC    = 2'd2,
        S_RESOLVE = 2'd3
    } state_t;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    state_t           state_q, state_d;
    logic [15:0]      instr_q, instr_d;
    logic             illegal_q, illegal_d;
    logic             pc_ctl_q, pc_ctl_d;
    logic [2:0]       dr_q, dr_d;
    logic [2:0]       sr1_q, sr1_d;
    logic [2:0]       sr2_q, sr2_d;
    logic             imm_en_q, imm_en_d;
    logic [15:0]      imm_q, imm_d;
    logic [15:0]      pc_offset_q, pc_offset_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] taken_q, taken_d;

    logic [3:0] opcode;
    logic       is_alu;
    logic       is_br;
    logic       in_exec;

    // Decode always works on the latched word, never on instr_in.
    assign opcode  = instr_q[15:12];
    assign is_alu  = (opcode == OP_ADD) || (opcode == OP_AND) || (opcode == OP_NOT);
    assign is_br   = (opcode == OP_BR);
    assign in_exec = (state_q == S_EXEC);

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        illegal_d   = illegal_q;
        pc_ctl_d    = pc_ctl_q;
        dr_d        = dr_q;
        sr1_d       = sr1_q;
        sr2_d       = sr2_q;
        imm_en_d    = imm_en_q;
        imm_d       = imm_q;
        pc_offset_d = pc_offset_q;
        retired_d   = retired_q;
        taken_d     = taken_q;

        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid_in) begin
                    instr_d = bus.instr_in;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Field registers load here so they are stable for the whole
                // EXEC/RESOLVE window and hold afterwards.
                if (is_alu) begin
                    dr_d     = instr_q[11:9];
                    sr1_d    = instr_q[8:6];
                    sr2_d    = instr_q[2:0];
                    imm_en_d = (opcode == OP_NOT) ? 1'b0 : instr_q[5];
                    imm_d    = {{11{instr_q[4]}}, instr_q[4:0]};
                    state_d  = S_EXEC;
                end else if (is_br) begin
                    pc_offset_d = {{7{instr_q[8]}}, instr_q[8:0]};
                    state_d     = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_EXEC: begin
                if (is_br) begin
                    // A 000 mask is a NOP branch: the decision is discarded.
                    pc_ctl_d = bus.pc_ctl_0_in & (|instr_q[11:9]);
                    state_d  = S_RESOLVE;
                end else begin
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = S_IDLE;
                end
            end
            S_RESOLVE: begin
                retired_d = retired_q + CNT_W'(1);
                if (pc_ctl_q) begin
                    taken_d = taken_q + CNT_W'(1);
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (reset_in) begin
            state_q     <= S_IDLE;
            instr_q     <= '0;
            illegal_q   <= 1'b0;
            pc_ctl_q    <= 1'b0;
            dr_q        <= '0;
            sr1_q       <= '0;
            sr2_q       <= '0;
            imm_en_q    <= 1'b0;
            imm_q       <= '0;
            pc_offset_q <= '0;
            retired_q   <= '0;
            taken_q     <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            illegal_q   <= illegal_d;
            pc_ctl_q    <= pc_ctl_d;
            dr_q        <= dr_d;
            sr1_q       <= sr1_d;
            sr2_q       <= sr2_d;
            imm_en_q    <= imm_en_d;
            imm_q       <= imm_d;
            pc_offset_q <= pc_offset_d;
            retired_q   <= retired_d;
            taken_q     <= taken_d;
        end
    end

    // Ready is masked by reset_in so the source never sees ready while reset is held.
    assign bus.instr_ready_out = (state_q == S_IDLE) && !reset_in;
    assign bus.we_reg_out      = in_exec && is_alu;
    assign bus.alu_op_out      = !(in_exec && is_alu) ? 2'b00 :
                                 (opcode == OP_AND)   ? 2'b01 :
                                 (opcode == OP_NOT)   ? 2'b10 : 2'b00;
    assign bus.br_out          = in_exec && is_br;
    assign bus.n_dec_out       = in_exec && is_br && instr_q[11];
    assign bus.z_dec_out       = in_exec && is_br && instr_q[10];
    assign bus.p_dec_out       = in_exec && is_br && instr_q[9];
    assign bus.pc_load_out     = (state_q == S_RESOLVE) && pc_ctl_q;
    assign bus.dr_out          = dr_q;
    assign bus.sr1_out         = sr1_q;
    assign bus.sr2_out         = sr2_q;
    assign bus.imm_en_out      = imm_en_q;
    assign bus.imm_out         = imm_q;
    assign bus.pc_offset_out   = pc_offset_q;
    assign bus.illegal_out     = illegal_q;
    assign bus.retired_cnt_out = retired_q;
    assign bus.taken_cnt_out   = taken_q;

endmodule

// File: tb/tb_branch_issue_fsm.sv
// tb/tb_branch_issue_fsm.sv - randomized self-checking bench for branch_issue_fsm
module tb_branch_issue_fsm;

    localparam int CW = 8;

    logic clka;
    logic reset_in;
    int   n_checks;
    int   n_errors;
    int   exp_retired;
    int   exp_taken;
    int   exp_illegal;

    branch_issue_fsm_if #(.CNT_W(CW)) bus ();

    branch_issue_fsm #(.CNT_W(CW)) dut (
        .clka     (clka),
        .reset_in (reset_in),
        .bus      (bus)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt_mod(input int v);
        return 32'(v % (1 << CW));
    endfunction

    task automatic idle_checks(input string tag);
        check_eq({tag, "_ready"}, 32'(bus.instr_ready_out), 32'd1);
        check_eq({tag, "_we"}, 32'(bus.we_reg_out), 32'd0);
        check_eq({tag, "_br"}, 32'(bus.br_out), 32'd0);
        check_eq({tag, "_pcload"}, 32'(bus.pc_load_out), 32'd0);
        check_eq({tag, "_illegal"}, 32'(bus.illegal_out), 32'(exp_illegal));
        check_eq({tag, "_retired"}, 32'(bus.retired_cnt_out), cnt_mod(exp_retired));
        check_eq({tag, "_taken"}, 32'(bus.taken_cnt_out), cnt_mod(exp_taken));
    endtask

    // Issues one instruction starting from a falling edge in the idle state and
    // returns at the falling edge where the block is idle again.
    task automatic run_instr(input logic [15:0] ins, input logic pc_ctl, input int gap,
                             input bit abort_in_exec);
        int n;
        int w;
        int opc;
        int v;
        int mask;
        int exp_load;
        w    = int'(ins);
        opc  = (w >> 12) & 15;
        mask = (w >> 9) & 7;
        for (int i = 0; i < gap; i++) begin
            bus.instr_valid_in = 1'b0;
            @(negedge clka);
            idle_checks("gap");
        end
        bus.instr_in       = ins;
        bus.instr_valid_in = 1'b1;
        bus.pc_ctl_0_in    = pc_ctl;
        n = 0;
        while (!bus.instr_ready_out && n < 8) begin
            @(negedge clka);
            n++;
        end
        check_eq("accept_ready", 32'(bus.instr_ready_out), 32'd1);
        @(negedge clka);
        bus.instr_valid_in = 1'b0;
        bus.instr_in       = 16'($urandom);
        check_eq("dec_ready", 32'(bus.instr_ready_out), 32'd0);
        check_eq("dec_we", 32'(bus.we_reg_out), 32'd0);
        check_eq("dec_br", 32'(bus.br_out), 32'd0);
        check_eq("dec_pcload", 32'(bus.pc_load_out), 32'd0);
        @(negedge clka);
        if (opc != 1 && opc != 5 && opc != 9 && opc != 0) begin
            exp_illegal = 1;
            check_eq("ill_flag", 32'(bus.illegal_out), 32'd1);
            check_eq("ill_ready", 32'(bus.instr_ready_out), 32'd1);
            check_eq("ill_we", 32'(bus.we_reg_out), 32'd0);
            check_eq("ill_br", 32'(bus.br_out), 32'd0);
            check_eq("ill_retired", 32'(bus.retired_cnt_out), cnt_mod(exp_retired));
        end else if (opc == 0) begin
            check_eq("br_req", 32'(bus.br_out), 32'd1);
            check_eq("br_n", 32'(bus.n_dec_out), 32'((w >> 11) & 1));
            check_eq("br_z", 32'(bus.z_dec_out), 32'((w >> 10) & 1));
            check_eq("br_p", 32'(bus.p_dec_out), 32'((w >> 9) & 1));
            v = w & 511;
            if (v > 255) v -= 512;
            check_eq("br_offset", 32'(bus.pc_offset_out), 32'(v & 16'hFFFF));
            check_eq("br_we", 32'(bus.we_reg_out), 32'd0);
            check_eq("br_ready", 32'(bus.instr_ready_out), 32'd0);
            if (abort_in_exec) begin
                reset_in = 1'b1;
                @(negedge clka);
                check_eq("rst_br", 32'(bus.br_out), 32'd0);
                check_eq("rst_pcload", 32'(bus.pc_load_out), 32'd0);
                check_eq("rst_ready", 32'(bus.instr_ready_out), 32'd0);
                reset_in    = 1'b0;
                exp_retired = 0;
                exp_taken   = 0;
                exp_illegal = 0;
                @(negedge clka);
                idle_checks("post_rst");
                return;
            end
            exp_load = (pc_ctl && mask != 0) ? 1 : 0;
            @(negedge clka);
            check_eq("res_pcload", 32'(bus.pc_load_out), 32'(exp_load));
            check_eq("res_br", 32'(bus.br_out), 32'd0);
            check_eq("res_ready", 32'(bus.instr_ready_out), 32'd0);
            check_eq("res_offset", 32'(bus.pc_offset_out), 32'(v & 16'hFFFF));
            exp_retired++;
            exp_taken += exp_load;
            @(negedge clka);
            idle_checks("br_done");
        end else begin
            check_eq("alu_we", 32'(bus.we_reg_out), 32'd1);
            check_eq("alu_op", 32'(bus.alu_op_out), (opc == 5) ? 32'd1 : (opc == 9) ? 32'd2 : 32'd0);
            check_eq("alu_dr", 32'(bus.dr_out), 32'((w >> 9) & 7));
            check_eq("alu_sr1", 32'(bus.sr1_out), 32'((w >> 6) & 7));
            check_eq("alu_sr2", 32'(bus.sr2_out), 32'(w & 7));
            check_eq("alu_imm_en", 32'(bus.imm_en_out), (opc == 9) ? 32'd0 : 32'((w >> 5) & 1));
            v = w & 31;
            if (v > 15) v -= 32;
            check_eq("alu_imm", 32'(bus.imm_out), 32'(v & 16'hFFFF));
            check_eq("alu_br", 32'(bus.br_out), 32'd0);
            check_eq("alu_ready", 32'(bus.instr_ready_out), 32'd0);
            exp_retired++;
            @(negedge clka);
            idle_checks("alu_done");
        end
    endtask

    function automatic logic [15:0] rand_instr();
        int r;
        logic [3:0] opc;
        logic [11:0] low;
        r   = int'($urandom_range(0, 9));
        low = 12'($urandom);
        if (r < 3)      opc = 4'b0001;
        else if (r < 5) opc = 4'b0101;
        else if (r < 7) opc = 4'b1001;
        else if (r < 9) opc = 4'b0000;
        else begin
            opc = 4'($urandom);
            while (opc == 4'b0001 || opc == 4'b0101 || opc == 4'b1001 || opc == 4'b0000)
                opc = 4'($urandom);
        end
        return {opc, low};
    endfunction

    initial begin
        n_checks           = 0;
        n_errors           = 0;
        exp_retired        = 0;
        exp_taken          = 0;
        exp_illegal        = 0;
        reset_in           = 1'b1;
        bus.instr_in       = 16'h0000;
        bus.instr_valid_in = 1'b0;
        bus.pc_ctl_0_in    = 1'b0;
        repeat (3) @(negedge clka);
        check_eq("rst_ready_low", 32'(bus.instr_ready_out), 32'd0);
        check_eq("rst_we", 32'(bus.we_reg_out), 32'd0);
        check_eq("rst_imm", 32'(bus.imm_out), 32'd0);
        check_eq("rst_offset", 32'(bus.pc_offset_out), 32'd0);
        check_eq("rst_retired", 32'(bus.retired_cnt_out), 32'd0);
        reset_in = 1'b0;
        repeat (5) begin
            @(negedge clka);
            idle_checks("idle");
        end

        run_instr(16'h1283, 1'b0, 0, 1'b0);
        run_instr(16'h5A7F, 1'b0, 1, 1'b0);
        run_instr(16'h09FE, 1'b1, 0, 1'b0);
        run_instr(16'h09FE, 1'b0, 0, 1'b0);
        run_instr(16'hF025, 1'b1, 0, 1'b0);
        run_instr(16'h1283, 1'b0, 0, 1'b0);
        run_instr(16'h0005, 1'b1, 0, 1'b0);
        run_instr(16'h0E10, 1'b1, 0, 1'b1);

        for (int k = 0; k < 400; k++) begin
            run_instr(rand_instr(), 1'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
